// File: rtl/dvi_link_ctrl.sv
// dvi_link_ctrl -- bring-up / teardown sequencer for the DVI output path.
// Runs entirely in the pixel-clock domain. Waits for a stable PLL lock, holds
// the sync/encode/serialize path in reset, blanks video for a few frames and
// then enables video. Tears down at a frame boundary and recovers from lock
// loss or a stalled sync generator (frame watchdog).
//
// Ports:
//   clk_i            pixel clock
//   rst_ni           asynchronous active-low reset
//   enable_i         level, 1 = link requested up
//   pll_locked_i     PLL lock, already synchronised to clk_i
//   frame_start_i    1-cycle pulse at the start of each frame
//   datapath_rst_o   registered active-high reset for the video datapath
//   blank_o          registered, 1 = force RGB to zero
//   link_up_o        registered, 1 only while video is active
//   state_o          current state (IDLE=0 .. DRAIN=5)
//   frame_timeout_o  1-cycle pulse when the frame watchdog expires
//   lock_loss_cnt_o  saturating count of lock losses after lock was qualified
module dvi_link_ctrl #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned BLANK_FRAMES       = 2,
  parameter int unsigned FRAME_TIMEOUT      = 1048576
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       pll_locked_i,
  input  logic       frame_start_i,
  output logic       datapath_rst_o,
  output logic       blank_o,
  output logic       link_up_o,
  output logic [2:0] state_o,
  output logic       frame_timeout_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int unsigned FW = $clog2(BLANK_FRAMES + 1);
  localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);

  // Each counter holds the number of qualifying cycles/pulses already seen,
  // so the terminal event fires when the counter sits at (limit - 1).
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);
  localparam logic [TW-1:0] WD_LAST    = TW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_RESET_HOLD = 3'd2,
    ST_BLANK      = 3'd3,
    ST_ACTIVE     = 3'd4,
    ST_DRAIN      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic [7:0]    loss_cnt_d;
  logic          timeout_d;
  logic          lost_d;
  logic          rst_d, blank_d, up_d;
  logic          wd_hit;

  assign wd_hit  = (wd_cnt_q == WD_LAST);
  assign state_o = state_q;

  // Next-state, counter and output decode; priority inside each state is
  // lock loss > enable low > watchdog > frame pulse > counter expiry.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = 1'b0;
    lost_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_WAIT_LOCK;
        else          state_d = ST_IDLE;
      end
      ST_WAIT_LOCK: begin
        // A dropout here only restarts qualification; it is not a loss event.
        if (!enable_i)                    state_d = ST_IDLE;
        else if (!pll_locked_i)           lock_cnt_d = '0;
        else if (lock_cnt_q == LOCK_LAST) state_d = ST_RESET_HOLD;
        else                              lock_cnt_d = lock_cnt_q + LW'(1);
      end
      ST_RESET_HOLD: begin
        if (!pll_locked_i)                lost_d = 1'b1;
        else if (!enable_i)               state_d = ST_IDLE;
        else if (hold_cnt_q == HOLD_LAST) state_d = ST_BLANK;
        else                              hold_cnt_d = hold_cnt_q + HW'(1);
      end
      ST_BLANK: begin
        if (!pll_locked_i)    lost_d = 1'b1;
        else if (!enable_i)   state_d = ST_IDLE;
        else if (wd_hit) begin
          state_d   = ST_RESET_HOLD;
          timeout_d = 1'b1;
        end else if (frame_start_i) begin
          wd_cnt_d = '0;
          if (frame_cnt_q == FRAME_LAST) state_d = ST_ACTIVE;
          else                           frame_cnt_d = frame_cnt_q + FW'(1);
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end
      ST_ACTIVE: begin
        if (!pll_locked_i)  lost_d = 1'b1;
        else if (!enable_i) state_d = ST_DRAIN;
        else if (wd_hit) begin
          state_d   = ST_RESET_HOLD;
          timeout_d = 1'b1;
        end else if (frame_start_i) wd_cnt_d = '0;
        else                        wd_cnt_d = wd_cnt_q + TW'(1);
      end
      ST_DRAIN: begin
        // Video keeps flowing until the frame in flight is finished.
        if (!pll_locked_i) lost_d = 1'b1;
        else if (enable_i) state_d = ST_ACTIVE;
        else if (wd_hit) begin
          state_d   = ST_RESET_HOLD;
          timeout_d = 1'b1;
        end else if (frame_start_i) state_d = ST_IDLE;
        else                        wd_cnt_d = wd_cnt_q + TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (lost_d) begin
      state_d = ST_WAIT_LOCK;
    end else begin
      state_d = state_d;
    end

    if (lost_d && (lock_loss_cnt_o != 8'hFF)) loss_cnt_d = lock_loss_cnt_o + 8'd1;
    else                                      loss_cnt_d = lock_loss_cnt_o;

    // Every state entry starts all counters from zero.
    if (state_d != state_q) begin
      lock_cnt_d  = '0;
      hold_cnt_d  = '0;
      frame_cnt_d = '0;
      wd_cnt_d    = '0;
    end else begin
      lock_cnt_d  = lock_cnt_d;
    end

    // Outputs are decoded from the next state so they register together with it.
    case (state_d)
      ST_IDLE, ST_WAIT_LOCK, ST_RESET_HOLD: begin
        rst_d = 1'b1; blank_d = 1'b1; up_d = 1'b0;
      end
      ST_BLANK: begin
        rst_d = 1'b0; blank_d = 1'b1; up_d = 1'b0;
      end
      ST_ACTIVE: begin
        rst_d = 1'b0; blank_d = 1'b0; up_d = 1'b1;
      end
      ST_DRAIN: begin
        rst_d = 1'b0; blank_d = 1'b0; up_d = 1'b0;
      end
      default: begin
        rst_d = 1'b1; blank_d = 1'b1; up_d = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      lock_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      frame_cnt_q     <= '0;
      wd_cnt_q        <= '0;
      datapath_rst_o  <= 1'b1;
      blank_o         <= 1'b1;
      link_up_o       <= 1'b0;
      frame_timeout_o <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else begin
      state_q         <= state_d;
      lock_cnt_q      <= lock_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      wd_cnt_q        <= wd_cnt_d;
      datapath_rst_o  <= rst_d;
      blank_o         <= blank_d;
      link_up_o       <= up_d;
      frame_timeout_o <= timeout_d;
      lock_loss_cnt_o <= loss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dvi_link_ctrl.sv
// tb_dvi_link_ctrl -- self-checking bench for dvi_link_ctrl.
// Directed bring-up/teardown scenarios followed by randomized stimulus, all
// checked every cycle against a behavioural model of the sequencer.
module tb_dvi_link_ctrl;

  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int BF  = 2;
  localparam int FT  = 1000;

  logic       clk = 1'b0;
  logic       rst_n, en, lk, fs;
  logic       datapath_rst, blank, link_up, frame_to;
  logic [2:0] state;
  logic [7:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: state number plus "how long / how many" tallies.
  int m_state, m_lock_run, m_hold_time, m_frames, m_since_frame, m_loss;
  bit m_to;

  dvi_link_ctrl #(
    .LOCK_STABLE_CYCLES(LSC),
    .RST_HOLD_CYCLES   (RHC),
    .BLANK_FRAMES      (BF),
    .FRAME_TIMEOUT     (FT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (en),
    .pll_locked_i   (lk),
    .frame_start_i  (fs),
    .datapath_rst_o (datapath_rst),
    .blank_o        (blank),
    .link_up_o      (link_up),
    .state_o        (state),
    .frame_timeout_o(frame_to),
    .lock_loss_cnt_o(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {17'd0, state, datapath_rst, blank, link_up, frame_to, loss_cnt};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [2:0] s;
    logic [7:0] c;
    s = 3'(m_state);
    c = 8'(m_loss);
    return {17'd0, s, logic'(m_state <= 2), logic'(m_state <= 3), logic'(m_state == 4), logic'(m_to), c};
  endfunction

  task automatic model_reset();
    m_state = 0; m_lock_run = 0; m_hold_time = 0; m_frames = 0;
    m_since_frame = 0; m_loss = 0; m_to = 1'b0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  lost;
    nxt  = m_state;
    lost = 1'b0;
    m_to = 1'b0;
    case (m_state)
      0: if (en) nxt = 1;
      1: begin
        if (!en) nxt = 0;
        else if (!lk) m_lock_run = 0;
        else begin
          m_lock_run++;
          if (m_lock_run >= LSC) nxt = 2;
        end
      end
      2: begin
        if (!lk) lost = 1'b1;
        else if (!en) nxt = 0;
        else begin
          m_hold_time++;
          if (m_hold_time >= RHC) nxt = 3;
        end
      end
      3, 4, 5: begin
        if (!lk) lost = 1'b1;
        else if (m_state != 5 && !en) nxt = (m_state == 3) ? 0 : 5;
        else if (m_state == 5 && en) nxt = 4;
        else if (m_since_frame + 1 >= FT) begin
          nxt  = 2;
          m_to = 1'b1;
        end else if (fs) begin
          m_since_frame = 0;
          if (m_state == 3) begin
            m_frames++;
            if (m_frames >= BF) nxt = 4;
          end else if (m_state == 5) nxt = 0;
        end else m_since_frame++;
      end
      default: nxt = 0;
    endcase
    if (lost) begin
      nxt = 1;
      if (m_loss < 255) m_loss++;
    end
    if (nxt != m_state) begin
      m_lock_run = 0; m_hold_time = 0; m_frames = 0; m_since_frame = 0;
    end
    m_state = nxt;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic tick(input logic e, input logic l, input logic f);
    en = e; lk = l; fs = f;
    @(posedge clk);
    model_step();
    #1;
    check_eq("cycle", dut_vec(), exp_vec());
    @(negedge clk);
  endtask

  // Drive enable+lock until the DUT sits in the requested state (bounded).
  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < 60 && state != 3'(target); i++) tick(1'b1, 1'b1, 1'b0);
    check_eq(tag, 32'(state), 32'(target));
  endtask

  task automatic bring_up();
    run_to(3, "reach_blank");
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    check_eq("reach_active", 32'(state), 32'd4);
  endtask

  initial begin
    int waitc, holdc, blankc, quiet;
    rst_n = 1'b0; en = 1'b0; lk = 1'b0; fs = 1'b0;
    model_reset();
    #23;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_dprst", 32'(datapath_rst), 32'd1);
    check_eq("rst_blank", 32'(blank), 32'd1);
    check_eq("rst_up",    32'(link_up), 32'd0);
    check_eq("rst_to",    32'(frame_to), 32'd0);
    check_eq("rst_loss",  32'(loss_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bring-up with lock high from the start.
    waitc = 0; holdc = 0;
    tick(1'b1, 1'b1, 1'b0);
    if (state == 3'd1) waitc++;
    for (int i = 0; i < 40 && state != 3'd3; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (state == 3'd1) waitc++;
      if (state == 3'd2 && datapath_rst) holdc++;
    end
    check_eq("wait_cycles", 32'(waitc), 32'd8);
    check_eq("hold_cycles", 32'(holdc), 32'd4);
    check_eq("blank_rst_low", 32'(datapath_rst), 32'd0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("blank_before_2nd", 32'(blank), 32'd1);
    tick(1'b1, 1'b1, 1'b1);
    check_eq("blank_after_2nd", 32'(blank), 32'd0);
    check_eq("link_up", 32'(link_up), 32'd1);

    // Lock drop while active.
    tick(1'b1, 1'b0, 1'b0);
    check_eq("drop_state", 32'(state), 32'd1);
    check_eq("drop_rst", 32'(datapath_rst), 32'd1);
    check_eq("drop_blank", 32'(blank), 32'd1);
    check_eq("drop_loss", 32'(loss_cnt), 32'd1);

    // Lock glitch at lock count 5 restarts qualification.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    waitc = 0;
    for (int i = 0; i < 20 && state != 3'd2; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      waitc++;
    end
    check_eq("glitch_relock", 32'(waitc), 32'd8);
    check_eq("glitch_loss", 32'(loss_cnt), 32'd1);

    // Drain: video stays on until the frame ends; re-enable returns to active.
    bring_up();
    tick(1'b0, 1'b1, 1'b0);
    check_eq("drain_state", 32'(state), 32'd5);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    check_eq("drain_blank", 32'(blank), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("drain_reenable", 32'(state), 32'd4);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    check_eq("drain_idle", 32'(state), 32'd0);
    check_eq("drain_idle_rst", 32'(datapath_rst), 32'd1);

    // Frame watchdog in BLANK.
    run_to(3, "to_blank");
    blankc = 0;
    for (int i = 0; i < 1100 && !frame_to; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      blankc++;
    end
    check_eq("timeout_cycles", 32'(blankc), 32'(FT));
    check_eq("timeout_state", 32'(state), 32'd2);
    check_eq("timeout_rst", 32'(datapath_rst), 32'd1);
    tick(1'b1, 1'b1, 1'b0);
    check_eq("timeout_pulse", 32'(frame_to), 32'd0);

    // Lock drop and enable low in the same cycle in BLANK.
    run_to(3, "to_blank2");
    tick(1'b0, 1'b0, 1'b0);
    check_eq("drop_en_state", 32'(state), 32'd1);
    check_eq("drop_en_loss", 32'(loss_cnt), 32'd2);

    // 300 lock losses saturate the counter.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 20 && state != 3'd2; i++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
    end
    check_eq("loss_saturate", 32'(loss_cnt), 32'd255);

    // Asynchronous reset mid-operation.
    bring_up();
    #2 rst_n = 1'b0;
    #1;
    check_eq("areset_vec", dut_vec(), {17'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional long frame gaps.
    quiet = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 1999) == 0) quiet = 1200;
      if (quiet > 0) quiet--;
      if ($urandom_range(0, 299) == 0) en = ~en;
      tick(en, ($urandom_range(0, 199) != 0),
           (quiet == 0) && ($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
